taxi_axil_wr_arb: RTL and testbench

- N:1 AXI4-Lite write-path arbiter.
- Shares one downstream AXI4-Lite write interface, typically feeding an AXI4-Lite to AXI4 write adapter, between S_COUNT upstream masters.
- Strictly one transaction outstanding; the B response is routed back to the granted source.
- Round-robin or fixed-priority selection, with a registered grant.

---
 rtl/taxi_axil_arb_pkg.sv | 10 +
 rtl/taxi_axil_if.sv | 35 +++
 rtl/taxi_arb_rr.sv | 31 +++
 rtl/taxi_axil_wr_arb.sv | 131 +++++++++++++
 tb/tb_taxi_axil_wr_arb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxi_axil_arb_pkg.sv
// taxi_axil_arb_pkg: state encoding and index sizing shared by the AXI4-Lite arbiters
package taxi_axil_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, RESP} arb_state_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// taxi_axil_if: AXI4-Lite write channels (AW, W, B) with master/slave views
interface taxi_axil_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int STRB_W   = DATA_W / 8,
    parameter int AWUSER_W = 1,
    parameter int WUSER_W  = 1,
    parameter int BUSER_W  = 1
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic [AWUSER_W-1:0] awuser;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic [WUSER_W-1:0]  wuser;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic [BUSER_W-1:0]  buser;
    logic                bvalid;
    logic                bready;

    modport wr_mst (
        output awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
        input  awready, wready, bresp, buser, bvalid
    );

    modport wr_slv (
        input  awaddr, awprot, awuser, awvalid, wdata, wstrb, wuser, wvalid, bready,
        output awready, wready, bresp, buser, bvalid
    );

endinterface

// File: rtl/taxi_arb_rr.sv
// taxi_arb_rr: combinational round-robin / fixed-priority picker over a request vector
module taxi_arb_rr
    import taxi_axil_arb_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter bit ROUND_ROBIN = 1'b1,
    localparam int IDX_W      = idx_w(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               vld_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    // walk the search order backwards so the highest-priority request lands last
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            cand = IDX_W'(((ROUND_ROBIN ? int'(ptr_i) : 0) + k) % S_COUNT);
            if (req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/taxi_axil_wr_arb.sv
// taxi_axil_wr_arb: N:1 AXI4-Lite write arbiter, one transaction outstanding, B routed to the granted source
module taxi_axil_wr_arb
    import taxi_axil_arb_pkg::*;
#(
    parameter int S_COUNT         = 4,
    parameter bit ARB_ROUND_ROBIN = 1'b1,
    localparam int IDX_W          = idx_w(S_COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axil_if.wr_slv      s_axil_wr [S_COUNT],
    taxi_axil_if.wr_mst      m_axil_wr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_index
);

    localparam int ADDR_W   = m_axil_wr.ADDR_W;
    localparam int DATA_W   = m_axil_wr.DATA_W;
    localparam int STRB_W   = m_axil_wr.STRB_W;
    localparam int AWUSER_W = m_axil_wr.AWUSER_W;
    localparam int WUSER_W  = m_axil_wr.WUSER_W;
    localparam int BUSER_W  = m_axil_wr.BUSER_W;

    arb_state_t       state_q, state_d;
    logic             grant_valid_q, grant_valid_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [IDX_W-1:0] grant_index_q, grant_index_d, ptr_q, ptr_d, arb_idx;
    logic             arb_vld, xfer, resp, m_awvalid, m_wvalid, m_bready;

    logic [ADDR_W-1:0]   s_awaddr [S_COUNT];
    logic [2:0]          s_awprot [S_COUNT];
    logic [AWUSER_W-1:0] s_awuser [S_COUNT];
    logic [DATA_W-1:0]   s_wdata  [S_COUNT];
    logic [STRB_W-1:0]   s_wstrb  [S_COUNT];
    logic [WUSER_W-1:0]  s_wuser  [S_COUNT];
    logic [S_COUNT-1:0]  s_awvalid, s_wvalid, s_bready, sel;

    taxi_arb_rr #(
        .S_COUNT    (S_COUNT),
        .ROUND_ROBIN(ARB_ROUND_ROBIN)
    ) u_arb (
        .req_i(s_awvalid),
        .ptr_i(ptr_q),
        .vld_o(arb_vld),
        .idx_o(arb_idx)
    );

    for (genvar n = 0; n < S_COUNT; n++) begin : g_src
        if (s_axil_wr[n].ADDR_W != ADDR_W || s_axil_wr[n].DATA_W != DATA_W ||
            s_axil_wr[n].STRB_W != STRB_W || s_axil_wr[n].AWUSER_W != AWUSER_W ||
            s_axil_wr[n].WUSER_W != WUSER_W || s_axil_wr[n].BUSER_W != BUSER_W) begin : g_chk
            $fatal(0, "taxi_axil_wr_arb: interface width mismatch on s_axil_wr[%0d]", n);
        end
        assign s_awaddr[n]  = s_axil_wr[n].awaddr;
        assign s_awprot[n]  = s_axil_wr[n].awprot;
        assign s_awuser[n]  = s_axil_wr[n].awuser;
        assign s_awvalid[n] = s_axil_wr[n].awvalid;
        assign s_wdata[n]   = s_axil_wr[n].wdata;
        assign s_wstrb[n]   = s_axil_wr[n].wstrb;
        assign s_wuser[n]   = s_axil_wr[n].wuser;
        assign s_wvalid[n]  = s_axil_wr[n].wvalid;
        assign s_bready[n]  = s_axil_wr[n].bready;
        assign sel[n]       = grant_valid_q && grant_index_q == IDX_W'(n);
        // readies depend only on registered grant state, never on any awvalid
        assign s_axil_wr[n].awready = sel[n] && xfer && !aw_done_q && m_axil_wr.awready;
        assign s_axil_wr[n].wready  = sel[n] && xfer && !w_done_q && m_axil_wr.wready;
        assign s_axil_wr[n].bvalid  = sel[n] && resp && m_axil_wr.bvalid;
        assign s_axil_wr[n].bresp   = sel[n] ? m_axil_wr.bresp : '0;
        assign s_axil_wr[n].buser   = sel[n] ? m_axil_wr.buser : '0;
    end

    assign xfer      = state_q == XFER;
    assign resp      = state_q == RESP;
    assign m_awvalid = xfer && s_awvalid[grant_index_q] && !aw_done_q;
    assign m_wvalid  = xfer && s_wvalid[grant_index_q] && !w_done_q;
    assign m_bready  = resp && s_bready[grant_index_q];

    assign m_axil_wr.awaddr  = s_awaddr[grant_index_q];
    assign m_axil_wr.awprot  = s_awprot[grant_index_q];
    assign m_axil_wr.awuser  = s_awuser[grant_index_q];
    assign m_axil_wr.awvalid = m_awvalid;
    assign m_axil_wr.wdata   = s_wdata[grant_index_q];
    assign m_axil_wr.wstrb   = s_wstrb[grant_index_q];
    assign m_axil_wr.wuser   = s_wuser[grant_index_q];
    assign m_axil_wr.wvalid  = m_wvalid;
    assign m_axil_wr.bready  = m_bready;

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        ptr_d         = ptr_q;
        aw_done_d     = aw_done_q || (m_awvalid && m_axil_wr.awready);
        w_done_d      = w_done_q || (m_wvalid && m_axil_wr.wready);
        if (state_q == IDLE && arb_vld) begin
            state_d       = XFER;
            grant_valid_d = 1'b1;
            grant_index_d = arb_idx;
            aw_done_d     = 1'b0;
            w_done_d      = 1'b0;
        end
        if (xfer && aw_done_d && w_done_d) state_d = RESP;
        if (m_bready && m_axil_wr.bvalid) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            ptr_d         = grant_index_q == IDX_W'(S_COUNT - 1) ? '0 : grant_index_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            ptr_q         <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            ptr_q         <= ptr_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
        end
    end

endmodule

// File: tb/tb_taxi_axil_wr_arb.sv
// tb_taxi_axil_wr_arb: directed checks of the write arbiter in round-robin and fixed-priority builds
module tb_taxi_axil_wr_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] s_awaddr [4];
    logic [31:0] s_wdata  [4];
    logic [3:0]  s_wstrb  [4];
    logic [3:0]  s_awvalid, s_wvalid, s_bready;
    logic [3:0]  r_awready, r_wready, r_bvalid, f_awready, f_bvalid;
    logic [1:0]  r_bresp [4];
    logic        m_awready, m_wready;
    logic [1:0]  m_bresp;
    logic        r_aw, r_w, r_b, f_aw, f_w, f_b;
    logic        r_gv, f_gv;
    logic [1:0]  r_gi, f_gi;
    int          aw_cnt = 0, w_cnt = 0, aw0, w0;
    int          n_cmp = 0, n_bad = 0;
    int          exp_g [5] = '{0, 1, 2, 3, 0};

    taxi_axil_if r_s [4] ();
    taxi_axil_if r_m ();
    taxi_axil_if f_s [4] ();
    taxi_axil_if f_m ();

    for (genvar i = 0; i < 4; i++) begin : g_src
        assign r_s[i].awaddr  = s_awaddr[i];
        assign r_s[i].awprot  = '0;
        assign r_s[i].awuser  = '0;
        assign r_s[i].awvalid = s_awvalid[i];
        assign r_s[i].wdata   = s_wdata[i];
        assign r_s[i].wstrb   = s_wstrb[i];
        assign r_s[i].wuser   = '0;
        assign r_s[i].wvalid  = s_wvalid[i];
        assign r_s[i].bready  = s_bready[i];
        assign f_s[i].awaddr  = s_awaddr[i];
        assign f_s[i].awprot  = '0;
        assign f_s[i].awuser  = '0;
        assign f_s[i].awvalid = s_awvalid[i];
        assign f_s[i].wdata   = s_wdata[i];
        assign f_s[i].wstrb   = s_wstrb[i];
        assign f_s[i].wuser   = '0;
        assign f_s[i].wvalid  = s_wvalid[i];
        assign f_s[i].bready  = s_bready[i];
        assign r_awready[i]   = r_s[i].awready;
        assign r_wready[i]    = r_s[i].wready;
        assign r_bvalid[i]    = r_s[i].bvalid;
        assign r_bresp[i]     = r_s[i].bresp;
        assign f_awready[i]   = f_s[i].awready;
        assign f_bvalid[i]    = f_s[i].bvalid;
    end

    assign r_m.awready = m_awready;
    assign r_m.wready  = m_wready;
    assign r_m.bvalid  = r_b;
    assign r_m.bresp   = m_bresp;
    assign r_m.buser   = '0;
    assign f_m.awready = 1'b1;
    assign f_m.wready  = 1'b1;
    assign f_m.bvalid  = f_b;
    assign f_m.bresp   = 2'd0;
    assign f_m.buser   = '0;

    // downstream slaves: raise bvalid the cycle after both AW and W have been accepted
    always @(posedge clk) begin
        if (rst) begin
            r_aw <= 1'b0; r_w <= 1'b0; r_b <= 1'b0;
        end else if (r_b) begin
            r_b <= !r_m.bready;
        end else if ((r_aw || (r_m.awvalid && m_awready)) && (r_w || (r_m.wvalid && m_wready))) begin
            r_b <= 1'b1; r_aw <= 1'b0; r_w <= 1'b0;
        end else begin
            r_aw <= r_aw || (r_m.awvalid && m_awready);
            r_w  <= r_w || (r_m.wvalid && m_wready);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            f_aw <= 1'b0; f_w <= 1'b0; f_b <= 1'b0;
        end else if (f_b) begin
            f_b <= !f_m.bready;
        end else if ((f_aw || f_m.awvalid) && (f_w || f_m.wvalid)) begin
            f_b <= 1'b1; f_aw <= 1'b0; f_w <= 1'b0;
        end else begin
            f_aw <= f_aw || f_m.awvalid;
            f_w  <= f_w || f_m.wvalid;
        end
    end

    always @(posedge clk) begin
        if (r_m.awvalid && m_awready) aw_cnt <= aw_cnt + 1;
        if (r_m.wvalid && m_wready) w_cnt <= w_cnt + 1;
    end

    taxi_axil_wr_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axil_wr  (r_s),
        .m_axil_wr  (r_m),
        .grant_valid(r_gv),
        .grant_index(r_gi)
    );

    taxi_axil_wr_arb #(.S_COUNT(4), .ARB_ROUND_ROBIN(1'b0)) dut_fp (
        .clk        (clk),
        .rst        (rst),
        .s_axil_wr  (f_s),
        .m_axil_wr  (f_m),
        .grant_valid(f_gv),
        .grant_index(f_gi)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            s_awaddr[i] = 32'h1000 + 32'(i) * 4;
            s_wdata[i]  = 32'hA000_0000 + 32'(i);
            s_wstrb[i]  = 4'hF;
        end
        s_awvalid = '0; s_wvalid = '0; s_bready = '1;
        m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_gv", r_gv, 0);
        chk("rst_gi", r_gi, 0);
        chk("rst_m_awvalid", r_m.awvalid, 0);
        chk("rst_m_wvalid", r_m.wvalid, 0);
        chk("rst_m_bready", r_m.bready, 0);
        chk("rst_s_rdy", {r_awready, r_wready, r_bvalid}, 0);
        rst = 1'b0;

        // single source 2
        s_awaddr[2] = 32'h40; s_wdata[2] = 32'hDEADBEEF;
        s_awvalid[2] = 1'b1; s_wvalid[2] = 1'b1;
        @(negedge clk);
        chk("t1_gv", r_gv, 1);
        chk("t1_gi", r_gi, 2);
        chk("t1_m_awvalid", r_m.awvalid, 1);
        chk("t1_m_awaddr", r_m.awaddr, 32'h40);
        chk("t1_m_wvalid", r_m.wvalid, 1);
        chk("t1_m_wdata", r_m.wdata, 32'hDEADBEEF);
        chk("t1_m_wstrb", r_m.wstrb, 4'hF);
        chk("t1_awready", r_awready, 4'b0100);
        chk("t1_wready", r_wready, 4'b0100);
        @(negedge clk);
        s_awvalid[2] = 1'b0; s_wvalid[2] = 1'b0;
        chk("t1_resp_gi", r_gi, 2);
        chk("t1_bvalid", r_bvalid, 4'b0100);
        chk("t1_bresp", r_bresp[2], 0);
        chk("t1_resp_m_awvalid", r_m.awvalid, 0);
        @(negedge clk);
        chk("t1_idle_gv", r_gv, 0);
        chk("t1_idle_bvalid", r_bvalid, 0);
        s_awaddr[2] = 32'h1008; s_wdata[2] = 32'hA000_0002;

        // all four sources, round-robin
        do_reset();
        s_awvalid = '1; s_wvalid = '1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("t2_gi", r_gi, exp_g[t]);
            chk("t2_m_awaddr", r_m.awaddr, 32'h1000 + 32'(exp_g[t]) * 4);
            chk("t2_m_wdata", r_m.wdata, 32'hA000_0000 + 32'(exp_g[t]));
            chk("t2_awready", r_awready, 32'd1 << exp_g[t]);
            chk("t2_wready", r_wready, 32'd1 << exp_g[t]);
            @(negedge clk);
            chk("t2_bvalid", r_bvalid, 32'd1 << exp_g[t]);
            if (t == 4) begin
                s_awvalid = '0; s_wvalid = '0;
            end
            @(negedge clk);
            chk("t2_idle_gv", r_gv, 0);
        end

        // sources 1 and 3: fixed priority starves 3, round-robin alternates
        do_reset();
        s_awvalid = 4'b1010; s_wvalid = 4'b1010;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("t3_fp_gv", f_gv, 1);
            chk("t3_fp_gi", f_gi, 1);
            chk("t3_fp_awready", f_awready, 4'b0010);
            chk("t3_rr_gi", r_gi, t == 1 ? 3 : 1);
            @(negedge clk);
            chk("t3_fp_bvalid", f_bvalid, 4'b0010);
            if (t == 2) begin
                s_awvalid = '0; s_wvalid = '0;
            end
            @(negedge clk);
        end

        // W before AW upstream, AW delayed downstream
        m_awready = 1'b0;
        s_wvalid[0] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t4_wfirst_gv", r_gv, 0);
            chk("t4_wfirst_wready", r_wready, 0);
        end
        s_awvalid[0] = 1'b1;
        aw0 = aw_cnt; w0 = w_cnt;
        @(negedge clk);
        chk("t4_gi", r_gi, 0);
        chk("t4_m_awvalid", r_m.awvalid, 1);
        chk("t4_awready", r_awready, 0);
        chk("t4_wready", r_wready, 4'b0001);
        @(negedge clk);
        s_wvalid[0] = 1'b0;
        chk("t4_wdone_m_wvalid", r_m.wvalid, 0);
        chk("t4_wdone_wready", r_wready, 0);
        chk("t4_wdone_wcnt", w_cnt - w0, 1);
        chk("t4_wdone_awcnt", aw_cnt - aw0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_awvalid", r_m.awvalid, 1);
            chk("t4_hold_wvalid", r_m.wvalid, 0);
            chk("t4_hold_bvalid", r_bvalid, 0);
        end
        m_awready = 1'b1;
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        chk("t4_bvalid", r_bvalid, 4'b0001);
        chk("t4_awcnt", aw_cnt - aw0, 1);
        chk("t4_wcnt", w_cnt - w0, 1);
        @(negedge clk);
        chk("t4_idle_gv", r_gv, 0);

        // SLVERR with upstream bready held off one cycle
        m_bresp = 2'd2; s_bready[1] = 1'b0;
        s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
        @(negedge clk);
        chk("t5_gi", r_gi, 1);
        @(negedge clk);
        s_awvalid[1] = 1'b0; s_wvalid[1] = 1'b0;
        chk("t5_bvalid", r_bvalid, 4'b0010);
        chk("t5_bresp", r_bresp[1], 2);
        chk("t5_bresp_other", r_bresp[0], 0);
        chk("t5_m_bready", r_m.bready, 0);
        @(negedge clk);
        chk("t5_stall_gv", r_gv, 1);
        chk("t5_stall_bvalid", r_bvalid, 4'b0010);
        s_bready[1] = 1'b1;
        @(negedge clk);
        chk("t5_idle_gv", r_gv, 0);
        chk("t5_idle_bvalid", r_bvalid, 0);
        m_bresp = 2'd0;

        // reset after AW only, then a clean transaction from pointer 0
        m_wready = 1'b0;
        s_awvalid[3] = 1'b1; s_wvalid[3] = 1'b1;
        @(negedge clk);
        chk("t6_gi", r_gi, 3);
        @(negedge clk);
        chk("t6_awdone_m_awvalid", r_m.awvalid, 0);
        chk("t6_awdone_m_wvalid", r_m.wvalid, 1);
        chk("t6_awdone_gv", r_gv, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_gv", r_gv, 0);
        chk("t6_rst_gi", r_gi, 0);
        chk("t6_rst_m_valid", {r_m.awvalid, r_m.wvalid, r_m.bready}, 0);
        chk("t6_rst_s_rdy", {r_awready, r_wready, r_bvalid}, 0);
        rst = 1'b0; m_wready = 1'b1;
        s_awvalid = 4'b0110; s_wvalid = 4'b0110;
        @(negedge clk);
        chk("t6_after_gi", r_gi, 1);
        chk("t6_after_awaddr", r_m.awaddr, 32'h1004);
        @(negedge clk);
        s_awvalid = '0; s_wvalid = '0;
        chk("t6_after_bvalid", r_bvalid, 4'b0010);
        @(negedge clk);
        chk("t6_after_idle_gv", r_gv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
